// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: key intake and round-key stream between the AES-128 key
// scheduler and its surroundings.
//   key_in/key_valid/key_ready  : cipher key intake (key_ready high only in IDLE)
//   rk_out/rk_round/rk_valid/rk_ready : round-key stream, rounds 0..10
//   busy                        : scheduler is not idle
// master = key source / round-key consumer, slave = the scheduler.
interface aes_key_sched_if;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned RND_W = 4;

    logic [KEY_W-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] rk_out;
    logic [RND_W-1:0] rk_round;
    logic             rk_valid;
    logic             rk_ready;
    logic             busy;

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_out, rk_round, rk_valid, busy
    );

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_out, rk_round, rk_valid, busy
    );
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched: sequential AES-128 key expansion. Latches a cipher key, then
// presents round keys 0..10 one at a time, with a single time-shared SubWord
// (four S-boxes) computing one expansion round per EXPAND cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_key_sched_if.slave (key intake, round-key stream, busy)
// Build option: define KEY_SCHED_ZEROIZE_EN to clear the key register on the
// final handshake and to force rk_out to zero whenever rk_valid is low.
module aes_key_sched (
    input  logic            clk,
    input  logic            rst_n,
    aes_key_sched_if.slave  bus
);
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(10);
    localparam logic [BYTE_W-1:0] RCON_INIT  = 8'h01;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_EXPAND  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [KEY_W-1:0]   r_key;
    logic [RND_W-1:0]   r_round;
    logic [BYTE_W-1:0]  r_rcon;

    logic               w_key_ready;
    logic               w_rk_valid;
    logic               w_busy;

    logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
    logic [WORD_W-1:0]  w_rot, w_sub, w_temp;
    logic [WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;
    logic [BYTE_W-1:0]  w_rcon_nxt;

    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] x);
        logic [10:0] top;
        top = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[top -: 8];
    endfunction

    // One expansion round, always computed from the current key register.
    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
    assign w_temp = w_sub ^ {r_rcon, 24'h0};
    assign w_n0   = w_w0 ^ w_temp;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.key_valid) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.rk_ready) begin
                    w_state_nxt = (r_round == LAST_ROUND) ? S_IDLE : S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_state_nxt = S_PRESENT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        w_key_ready = 1'b0;
        w_rk_valid  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_key_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_PRESENT: begin
                w_rk_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Key, round counter and rcon.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= RCON_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.key_valid) begin
                        r_key   <= bus.key_in;
                        r_round <= '0;
                        r_rcon  <= RCON_INIT;
                    end
                end
                S_PRESENT: begin
`ifdef KEY_SCHED_ZEROIZE_EN
                    if (bus.rk_ready && (r_round == LAST_ROUND)) begin
                        r_key  <= '0;
                        r_rcon <= RCON_INIT;
                    end
`endif
                end
                S_EXPAND: begin
                    r_key   <= {w_n0, w_n1, w_n2, w_n3};
                    r_rcon  <= w_rcon_nxt;
                    r_round <= r_round + RND_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.key_ready = w_key_ready;
    assign bus.rk_valid  = w_rk_valid;
    assign bus.busy      = w_busy;
    assign bus.rk_round  = r_round;
`ifdef KEY_SCHED_ZEROIZE_EN
    assign bus.rk_out    = w_rk_valid ? r_key : '0;
`else
    assign bus.rk_out    = r_key;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: directed checks of aes_key_sched against FIPS-197 and
// all-zero-key expansion vectors. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_aes_key_sched;
    logic clk = 1'b0;
    logic rst_n;

    aes_key_sched_if bus ();

    aes_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // rk_out while rk_valid is low: last key, or zero in the zeroize build.
    function automatic logic [127:0] hidden_rk(input logic [127:0] k);
`ifdef KEY_SCHED_ZEROIZE_EN
        return '0;
`else
        return k;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_ready  = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got=%0b exp=1", bus.key_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got=%0b exp=0", bus.rk_valid); end
        checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out got=%h exp=0", bus.rk_out); end
        checks++; if (bus.rk_round !== 4'd0) begin errors++; $display("FAIL reset_rk_round got=%0d exp=0", bus.rk_round); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
            errors++; $display("FAIL idle_hold key_ready=%0b rk_valid=%0b exp 1/0", bus.key_ready, bus.rk_valid);
        end
    endtask

    // Exact-cycle FIPS run with rk_ready=1, then the zero key in the first IDLE cycle.
    task automatic test_fips_back_to_back();
        bus.rk_ready  = 1'b1;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        for (int n = 0; n <= 10; n++) begin
            checks++; if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin
                errors++; $display("FAIL fips_present_flags round %0d valid=%0b busy=%0b key_ready=%0b exp 1/1/0",
                                   n, bus.rk_valid, bus.busy, bus.key_ready);
            end
            checks++; if (bus.rk_round !== 4'(n)) begin errors++; $display("FAIL fips_round got=%0d exp=%0d", bus.rk_round, n); end
            checks++; if (bus.rk_out !== FIPS_RK[n]) begin errors++; $display("FAIL fips_rk%0d got=%h exp=%h", n, bus.rk_out, FIPS_RK[n]); end
            @(negedge clk);
            if (n < 10) begin
                checks++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL fips_expand round %0d valid=%0b busy=%0b exp 0/1", n, bus.rk_valid, bus.busy);
                end
                checks++; if (bus.rk_out !== hidden_rk(FIPS_RK[n])) begin
                    errors++; $display("FAIL fips_expand_rk_out round %0d got=%h exp=%h", n, bus.rk_out, hidden_rk(FIPS_RK[n]));
                end
                @(negedge clk);
            end
        end
        checks++; if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
            errors++; $display("FAIL fips_done key_ready=%0b busy=%0b valid=%0b exp 1/0/0", bus.key_ready, bus.busy, bus.rk_valid);
        end
        checks++; if (bus.rk_out !== hidden_rk(FIPS_RK[10])) begin
            errors++; $display("FAIL fips_done_rk_out got=%h exp=%h", bus.rk_out, hidden_rk(FIPS_RK[10]));
        end
        bus.key_in    = '0;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            checks++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(n)) begin
                errors++; $display("FAIL zero_present round %0d valid=%0b rk_round=%0d", n, bus.rk_valid, bus.rk_round);
            end
            if (n == 0) begin
                checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL zero_rk0 got=%h exp=0", bus.rk_out); end
            end
            if (n == 1) begin
                checks++; if (bus.rk_out !== ZERO_R1) begin errors++; $display("FAIL zero_rk1 got=%h exp=%h", bus.rk_out, ZERO_R1); end
            end
            if (n == 10) begin
                checks++; if (bus.rk_out !== ZERO_R10) begin errors++; $display("FAIL zero_rk10 got=%h exp=%h", bus.rk_out, ZERO_R10); end
            end
            @(negedge clk);
            if (n < 10) @(negedge clk);
        end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL zero_done key_ready got=%0b exp=1", bus.key_ready); end
    endtask

    task automatic test_backpressure();
        int w;
        bus.rk_ready  = 1'b1;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            w = 0;
            while (bus.rk_valid !== 1'b1 && w < 4) begin @(negedge clk); w++; end
            checks++; if (bus.rk_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout round %0d valid=%0b exp=1", n, bus.rk_valid); end
            checks++; if (bus.rk_round !== 4'(n) || bus.rk_out !== FIPS_RK[n]) begin
                errors++; $display("FAIL bp_rk round %0d got_round=%0d got=%h exp=%h", n, bus.rk_round, bus.rk_out, FIPS_RK[n]);
            end
            if (n == 3) begin
                bus.rk_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd3 || bus.rk_out !== FIPS_RK[3]) begin
                        errors++; $display("FAIL bp_stall cycle %0d valid=%0b round=%0d rk=%h", s, bus.rk_valid, bus.rk_round, bus.rk_out);
                    end
                end
                bus.rk_ready = 1'b1;
            end
            @(negedge clk);
        end
        w = 0;
        while (bus.key_ready !== 1'b1 && w < 4) begin @(negedge clk); w++; end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL bp_done key_ready got=%0b exp=1", bus.key_ready); end
    endtask

    task automatic test_key_while_busy();
        int w;
        bus.rk_ready  = 1'b1;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            w = 0;
            while (bus.rk_valid !== 1'b1 && w < 4) begin @(negedge clk); w++; end
            if (n == 4) begin
                checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL busy_key_ready got=%0b exp=0", bus.key_ready); end
                bus.key_in    = OTHER_KEY;
                bus.key_valid = 1'b1;
            end
            if (n == 6) begin
                bus.key_valid = 1'b0;
                bus.key_in    = '0;
            end
            checks++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(n) || bus.rk_out !== FIPS_RK[n]) begin
                errors++; $display("FAIL busy_rk round %0d valid=%0b got_round=%0d got=%h exp=%h",
                                   n, bus.rk_valid, bus.rk_round, bus.rk_out, FIPS_RK[n]);
            end
            @(negedge clk);
        end
        w = 0;
        while (bus.key_ready !== 1'b1 && w < 4) begin @(negedge clk); w++; end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL busy_done key_ready got=%0b exp=1", bus.key_ready); end
    endtask

    task automatic test_reset_mid();
        int w;
        bus.rk_ready  = 1'b1;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        for (int n = 0; n <= 6; n++) begin
            w = 0;
            while (bus.rk_valid !== 1'b1 && w < 4) begin @(negedge clk); w++; end
            @(negedge clk);
        end
        // Round-6 handshake done: now in the EXPAND cycle.
        checks++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_expand valid=%0b busy=%0b exp 0/1", bus.rk_valid, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset valid=%0b key_ready=%0b busy=%0b exp 0/1/0", bus.rk_valid, bus.key_ready, bus.busy);
        end
        checks++; if (bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0) begin
            errors++; $display("FAIL mid_reset_rk got=%h round=%0d exp 0/0", bus.rk_out, bus.rk_round);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            w = 0;
            while (bus.rk_valid !== 1'b1 && w < 4) begin @(negedge clk); w++; end
            checks++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(n) || bus.rk_out !== FIPS_RK[n]) begin
                errors++; $display("FAIL mid_fresh round %0d valid=%0b got_round=%0d got=%h exp=%h",
                                   n, bus.rk_valid, bus.rk_round, bus.rk_out, FIPS_RK[n]);
            end
            @(negedge clk);
        end
        checks++; if (bus.key_ready !== 1'b1 || bus.rk_out !== hidden_rk(FIPS_RK[10])) begin
            errors++; $display("FAIL mid_done key_ready=%0b rk=%h exp 1/%h", bus.key_ready, bus.rk_out, hidden_rk(FIPS_RK[10]));
        end
    endtask

    initial begin
        test_reset();
        test_fips_back_to_back();
        test_backpressure();
        test_key_while_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
